// File: rtl/modexp_io_ctrl_if.sv
// Stream-in / core / stream-out signal bundle for the modular-exponentiation I/O controller.
// The master modport is the controller's view; slave is the view of the core and stream peers.
interface modexp_io_ctrl_if;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          exp_start;
  logic [15:0]   exp_e;
  logic [1023:0] exp_msg;
  logic [1023:0] exp_n;
  logic [1023:0] exp_rmodn;
  logic [1023:0] exp_r2modn;
  logic          exp_done;
  logic [1023:0] exp_result;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic          busy;

  modport master (
    input  s_valid, s_data, exp_done, exp_result, m_ready,
    output s_ready, exp_start, exp_e, exp_msg, exp_n, exp_rmodn, exp_r2modn,
           m_valid, m_data, m_last, busy
  );

  modport slave (
    output s_valid, s_data, exp_done, exp_result, m_ready,
    input  s_ready, exp_start, exp_e, exp_msg, exp_n, exp_rmodn, exp_r2modn,
           m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/modexp_io_ctrl.sv
// Loads a 129-word operand frame, kicks the exponentiation core once, and streams
// the 1024-bit result back out as 32 words, least-significant word first.
//
// state  | meaning
// LD_EXP | idle, waiting for the exponent word
// LD_MSG | shifting in 32 message words
// LD_N   | shifting in 32 modulus words
// LD_R   | shifting in 32 R mod N words
// LD_R2  | shifting in 32 R^2 mod N words
// START  | one-cycle start pulse to the core
// WAIT   | waiting for core completion
// UNLOAD | streaming the captured result out
module modexp_io_ctrl #(
  parameter int WORDS = 32
) (
  input  logic               clk,
  input  logic               resetn,
  modexp_io_ctrl_if.master   bus
);
  localparam int OPW = WORDS * 32;

  typedef enum logic [2:0] {
    LD_EXP, LD_MSG, LD_N, LD_R, LD_R2, START, WAIT, UNLOAD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_cnt;
  logic [15:0]      r_e;
  logic [OPW-1:0]   r_msg;
  logic [OPW-1:0]   r_n;
  logic [OPW-1:0]   r_rmodn;
  logic [OPW-1:0]   r_r2modn;
  logic [OPW-1:0]   r_out;
  logic             w_loading;
  logic             w_s_hs;
  logic             w_m_hs;
  logic             w_cnt_last;

  assign w_loading  = (r_state == LD_EXP) || (r_state == LD_MSG) || (r_state == LD_N) ||
                      (r_state == LD_R)   || (r_state == LD_R2);
  assign w_s_hs     = bus.s_valid && w_loading;
  assign w_m_hs     = bus.m_ready && (r_state == UNLOAD);
  assign w_cnt_last = (r_cnt == 5'(WORDS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_EXP:  if (w_s_hs) w_next = LD_MSG;
      LD_MSG:  if (w_s_hs && w_cnt_last) w_next = LD_N;
      LD_N:    if (w_s_hs && w_cnt_last) w_next = LD_R;
      LD_R:    if (w_s_hs && w_cnt_last) w_next = LD_R2;
      LD_R2:   if (w_s_hs && w_cnt_last) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (bus.exp_done) w_next = UNLOAD;
      UNLOAD:  if (w_m_hs && w_cnt_last) w_next = LD_EXP;
      default: w_next = LD_EXP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= LD_EXP;
      r_cnt    <= '0;
      r_e      <= '0;
      r_msg    <= '0;
      r_n      <= '0;
      r_rmodn  <= '0;
      r_r2modn <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_next;
      // Operand words arrive LSW first, so each new word enters at the top and drifts down.
      case (r_state)
        LD_EXP: if (w_s_hs) r_e <= bus.s_data[15:0];
        LD_MSG: if (w_s_hs) begin
          r_msg <= {bus.s_data, r_msg[OPW-1:32]};
          r_cnt <= r_cnt + 5'd1;
        end
        LD_N: if (w_s_hs) begin
          r_n   <= {bus.s_data, r_n[OPW-1:32]};
          r_cnt <= r_cnt + 5'd1;
        end
        LD_R: if (w_s_hs) begin
          r_rmodn <= {bus.s_data, r_rmodn[OPW-1:32]};
          r_cnt   <= r_cnt + 5'd1;
        end
        LD_R2: if (w_s_hs) begin
          r_r2modn <= {bus.s_data, r_r2modn[OPW-1:32]};
          r_cnt    <= r_cnt + 5'd1;
        end
        WAIT: if (bus.exp_done) begin
          r_out <= bus.exp_result;
          r_cnt <= '0;
        end
        UNLOAD: if (w_m_hs) begin
          r_out <= {32'h0, r_out[OPW-1:32]};
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready    = w_loading;
  assign bus.exp_start  = (r_state == START);
  assign bus.exp_e      = r_e;
  assign bus.exp_msg    = r_msg;
  assign bus.exp_n      = r_n;
  assign bus.exp_rmodn  = r_rmodn;
  assign bus.exp_r2modn = r_r2modn;
  assign bus.m_valid    = (r_state == UNLOAD);
  assign bus.m_data     = r_out[31:0];
  assign bus.m_last     = (r_state == UNLOAD) && w_cnt_last;
  assign bus.busy       = (r_state != LD_EXP);
endmodule

// File: tb/tb_modexp_io_ctrl.sv
// Directed-plus-random bench for modexp_io_ctrl: frames are built as word arrays and
// expected operands/results are formed by concatenating those words.
module tb_modexp_io_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  modexp_io_ctrl_if bus();

  modexp_io_ctrl #(.WORDS(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0]   fw [129];
  logic [1023:0] res;
  bit            ab;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int bad = 0;
    for (int i = 31; i >= 0; i--) if (obs[32*i +: 32] !== exp[32*i +: 32]) bad = i;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s word %0d observed=%h expected=%h", tag, bad, obs[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  task automatic timeout(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s observed=no-progress expected=completion", tag);
  endtask

  // Operand as seen by the core: word i of the section is bits [32i+31:32i].
  function automatic logic [1023:0] model_op(input int base);
    logic [1023:0] v = '0;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = fw[base + i];
    return v;
  endfunction

  task automatic chk_reset_vals(input string w);
    chk({w, "_s_ready"},   bus.s_ready,   1);
    chk({w, "_exp_start"}, bus.exp_start, 0);
    chk({w, "_m_valid"},   bus.m_valid,   0);
    chk({w, "_m_last"},    bus.m_last,    0);
    chk({w, "_busy"},      bus.busy,      0);
    chk({w, "_m_data"},    bus.m_data,    0);
    chk({w, "_exp_e"},     bus.exp_e,     0);
    chk_wide({w, "_msg"},  bus.exp_msg,   '0);
    chk_wide({w, "_n"},    bus.exp_n,     '0);
    chk_wide({w, "_r"},    bus.exp_rmodn, '0);
    chk_wide({w, "_r2"},   bus.exp_r2modn,'0);
  endtask

  task automatic do_reset(input string w);
    bus.s_valid  = 1'b0;
    bus.m_ready  = 1'b0;
    bus.exp_done = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_vals(w);
    resetn = 1'b1;
  endtask

  task automatic chk_operands(input string w);
    chk({w, "_exp_e"}, bus.exp_e, fw[0][15:0]);
    chk_wide({w, "_msg"}, bus.exp_msg,    model_op(1));
    chk_wide({w, "_n"},   bus.exp_n,      model_op(33));
    chk_wide({w, "_r"},   bus.exp_rmodn,  model_op(65));
    chk_wide({w, "_r2"},  bus.exp_r2modn, model_op(97));
  endtask

  task automatic load_frame(input bit rnd, input int spur_at, input int abort_at, output bit aborted);
    int idx = 0;
    int guard = 0;
    aborted = 1'b0;
    while (idx < 129) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin timeout("load_timeout"); return; end
      if (idx == abort_at) begin do_reset("abort_ld"); aborted = 1'b1; return; end
      chk("ld_s_ready",   bus.s_ready,   1);
      chk("ld_exp_start", bus.exp_start, 0);
      chk("ld_m_valid",   bus.m_valid,   0);
      chk("ld_busy",      bus.busy,      64'(idx != 0));
      bus.exp_done = (idx == spur_at);
      bus.s_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data   = fw[idx];
      if (bus.s_valid) idx++;
    end
    @(negedge clk);
    bus.exp_done = 1'b0;
    chk("st_exp_start", bus.exp_start, 1);
    chk("st_s_ready",   bus.s_ready,   0);
    chk("st_busy",      bus.busy,      1);
    chk("st_m_valid",   bus.m_valid,   0);
    chk_operands("st");
    bus.s_valid = 1'b1;
    bus.s_data  = $urandom;
    @(negedge clk);
    chk("wt_exp_start", bus.exp_start, 0);
    chk("wt_s_ready",   bus.s_ready,   0);
    chk_operands("wt");
  endtask

  task automatic unload_frame(input bit bp, input int hold, input int delay, input int abort_at);
    int j = 0;
    int guard = 0;
    int left;
    int cyc = 0;
    for (int k = 0; k < delay; k++) begin
      bus.exp_done   = 1'b0;
      bus.exp_result = ~res;
      bus.s_data     = $urandom;
      @(negedge clk);
      chk("wait_exp_start", bus.exp_start, 0);
      chk("wait_s_ready",   bus.s_ready,   0);
      chk("wait_m_valid",   bus.m_valid,   0);
      chk("wait_busy",      bus.busy,      1);
    end
    bus.exp_result = res;
    bus.exp_done   = 1'b1;
    left = hold - 1;
    while (j < 32) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin timeout("unload_timeout"); return; end
      chk("ul_m_valid", bus.m_valid, 1);
      chk("ul_m_data",  bus.m_data,  res[32*j +: 32]);
      chk("ul_m_last",  bus.m_last,  64'(j == 31));
      chk("ul_s_ready", bus.s_ready, 0);
      chk("ul_exp_start", bus.exp_start, 0);
      if (j == abort_at) begin do_reset("abort_ul"); return; end
      bus.exp_done = (left > 0);
      if (left > 0) left--;
      if (!bus.exp_done) bus.exp_result = ~res;
      bus.s_data  = $urandom;
      bus.m_ready = bp ? 1'(cyc % 2) : 1'b1;
      cyc++;
      if (bus.m_ready) j++;
    end
    @(negedge clk);
    chk("end_m_valid", bus.m_valid, 0);
    chk("end_m_last",  bus.m_last,  0);
    chk("end_s_ready", bus.s_ready, 1);
    chk("end_busy",    bus.busy,    0);
    bus.m_ready  = 1'b0;
    bus.exp_done = 1'b0;
    bus.s_valid  = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      bus.s_valid = 1'b0;
      bus.m_ready = 1'b1;
      @(negedge clk);
      chk("idle_exp_start", bus.exp_start, 0);
      chk("idle_m_valid",   bus.m_valid,   0);
      chk("idle_s_ready",   bus.s_ready,   1);
      chk("idle_busy",      bus.busy,      0);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic fill_fixed();
    fw[0] = 32'h0000_0011;
    for (int k = 0; k < 32; k++) begin
      fw[1 + k]  = k;
      fw[33 + k] = 32'hFFFF_FFFF;
      fw[65 + k] = 32'h1;
      fw[97 + k] = 32'h2;
      res[32*k +: 32] = k + 1;
    end
  endtask

  task automatic fill_rand(input logic [31:0] ew);
    fw[0] = ew;
    for (int k = 1; k < 129; k++) fw[k] = $urandom;
    for (int k = 0; k < 32; k++) res[32*k +: 32] = $urandom;
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.exp_done   = 1'b0;
    bus.exp_result = '0;
    bus.m_ready    = 1'b0;
    resetn         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    resetn = 1'b1;

    fill_fixed();
    load_frame(1'b0, -1, -1, ab);
    chk("fix_msg_w0",  bus.exp_msg[31:0],     0);
    chk("fix_msg_w31", bus.exp_msg[1023:992], 31);
    chk("fix_exp_e",   bus.exp_e,             16'h0011);
    unload_frame(1'b0, 1, 3, -1);

    load_frame(1'b1, -1, -1, ab);
    unload_frame(1'b1, 1, 5, -1);

    fill_rand($urandom);
    load_frame(1'b1, 40, -1, ab);
    unload_frame(1'b0, 10, 2, -1);

    fill_rand($urandom);
    load_frame(1'b0, -1, 70, ab);
    chk("abort_flag", 64'(ab), 1);
    idle_check(3);
    fill_rand($urandom);
    load_frame(1'b0, -1, -1, ab);
    unload_frame(1'b0, 1, 1, 5);
    idle_check(5);

    fill_rand(32'hFFFF_8001);
    load_frame(1'b1, -1, -1, ab);
    chk("exp_hi_ignored", bus.exp_e, 16'h8001);
    unload_frame(1'b1, 3, 0, -1);
    idle_check(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
